// File: rtl/rx_frame_stats_pkg.sv
// Shared types and helpers for the RX frame statistics stage.
package rx_frame_stats_pkg;

  // Widest tkeep the helpers accept; callers zero-extend narrower vectors.
  localparam int KEEP_MAX = 256;
  // Widest counter the saturating adder supports.
  localparam int SUM_MAX  = 64;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_IN_FRAME = 1'b1
  } frame_state_e;

  // Number of set tkeep bits, i.e. bytes carried by one beat.
  function automatic logic [15:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      n = n + {15'd0, keep[i]};
    end
    return n;
  endfunction

  // True when the set bits form one run starting at bit 0 (all-zero also passes,
  // so callers reject an empty tkeep separately). Zero-extension keeps this valid
  // for any narrower tkeep, including all-ones.
  function automatic logic keep_contiguous(input logic [KEEP_MAX-1:0] keep);
    logic [KEEP_MAX-1:0] plus1;
    plus1 = keep + KEEP_MAX'(1);
    return ((keep & plus1) == '0);
  endfunction

  // a + b clamped to 2^width-1; width is the counter width of the caller.
  function automatic logic [SUM_MAX-1:0] sat_add(input logic [SUM_MAX-1:0] a,
                                                 input logic [SUM_MAX-1:0] b,
                                                 input int unsigned        width);
    logic [SUM_MAX:0] sum;
    logic [SUM_MAX:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ({{SUM_MAX{1'b0}}, 1'b1} << width) - {{SUM_MAX{1'b0}}, 1'b1};
    if (sum > lim) begin
      return lim[SUM_MAX-1:0];
    end
    return sum[SUM_MAX-1:0];
  endfunction

endpackage

// File: rtl/rx_frame_stats_skid.sv
// Two-entry AXI-Stream skid buffer; decouples the downstream tready path from
// the upstream by registering s_axis_tready as "not full".
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_rx,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [ENTRY_W-1:0] mem_q [2];
  logic [ENTRY_W-1:0] mem_d [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               ready_q, ready_d;
  logic               push;
  logic               pop;

  // ready_q is low whenever the buffer holds two beats, so a push never overflows.
  assign push = s_axis_tvalid & ready_q;
  assign pop  = (count_q != 2'd0) & m_axis_tready;

  // Pointer/occupancy bookkeeping and the write into the free entry.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != 2'd2);
  end

  // Control registers; ready stays low during reset and rises on the first edge after.
  always_ff @(posedge clk_rx or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    // Storage for one buffered beat.
    always_ff @(posedge clk_rx or negedge aresetn) begin
      if (!aresetn) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = (count_q != 2'd0);
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q];

endmodule

// File: rtl/rx_frame_stats.sv
// RX stream pass-through with per-frame and cumulative statistics.
module rx_frame_stats
  import rx_frame_stats_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk_rx,
  input  logic                       aresetn,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  input  logic                       stats_clear,
  output logic                       frame_done,
  output logic [CNT_WIDTH-1:0]       last_frame_bytes,
  output logic [CNT_WIDTH-1:0]       min_frame_bytes,
  output logic [CNT_WIDTH-1:0]       max_frame_bytes,
  output logic [CNT_WIDTH-1:0]       frame_count,
  output logic [CNT_WIDTH-1:0]       byte_count,
  output logic [CNT_WIDTH-1:0]       error_count
);

  localparam int BYTES_W = $clog2(AXIS_KEEP_WIDTH + 1);

  axis_skid_buffer #(
    .DATA_WIDTH (AXIS_DATA_WIDTH),
    .KEEP_WIDTH (AXIS_KEEP_WIDTH)
  ) u_skid (
    .clk_rx        (clk_rx),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  // ---------------------------------------------------------------- beat decode
  logic                 accept;
  logic                 frame_end;
  logic [KEEP_MAX-1:0]  keep_ext;
  logic [15:0]          pop_wide;
  logic [BYTES_W-1:0]   beat_bytes;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 keep_full;
  logic                 keep_contig;
  logic                 beat_malformed;

  // Statistics follow what the upstream hands over, not what leaves downstream.
  assign accept      = s_axis_tvalid & s_axis_tready;
  assign frame_end   = accept & s_axis_tlast;
  assign keep_ext    = {{(KEEP_MAX - AXIS_KEEP_WIDTH){1'b0}}, s_axis_tkeep};
  assign pop_wide    = keep_popcount(keep_ext);
  assign beat_bytes  = pop_wide[BYTES_W-1:0];
  assign beat_cnt    = CNT_WIDTH'(beat_bytes);
  assign keep_full   = &s_axis_tkeep;
  assign keep_contig = keep_contiguous(keep_ext);
  // Middle beats must be full; the last beat must be a non-empty LSB-aligned run.
  assign beat_malformed = s_axis_tlast ? ((s_axis_tkeep == '0) | ~keep_contig)
                                       : ~keep_full;

  // ---------------------------------------------------------------- frame FSM
  frame_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_MAX-1:0]   acc_sum_w;
  logic [CNT_WIDTH-1:0] frame_total;

  assign acc_sum_w   = sat_add(SUM_MAX'(acc_q), SUM_MAX'(beat_cnt), CNT_WIDTH);
  // A tlast seen in IDLE is a single-beat frame, so the accumulator is bypassed.
  assign frame_total = (state_q == ST_IDLE) ? beat_cnt : acc_sum_w[CNT_WIDTH-1:0];

  // Next-state and accumulator update on each accepted beat.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!s_axis_tlast) begin
            state_d = ST_IN_FRAME;
            acc_d   = beat_cnt;
          end
        end
        ST_IN_FRAME: begin
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
          end else begin
            acc_d = acc_sum_w[CNT_WIDTH-1:0];
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state and in-progress frame length.
  always_ff @(posedge clk_rx or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // ---------------------------------------------------------------- statistics
  logic                 frame_done_q, frame_done_d;
  logic [CNT_WIDTH-1:0] last_q, last_d;
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] ecnt_q, ecnt_d;
  logic [SUM_MAX-1:0]   fcnt_inc_w;
  logic [SUM_MAX-1:0]   bcnt_sum_w;
  logic [SUM_MAX-1:0]   ecnt_inc_w;

  assign fcnt_inc_w = sat_add(SUM_MAX'(fcnt_q), SUM_MAX'(1), CNT_WIDTH);
  assign bcnt_sum_w = sat_add(SUM_MAX'(bcnt_q), SUM_MAX'(frame_total), CNT_WIDTH);
  assign ecnt_inc_w = sat_add(SUM_MAX'(ecnt_q), SUM_MAX'(1), CNT_WIDTH);

  // Frame-end and error updates; a coincident clear overrides the cumulative ones
  // but leaves last_frame_bytes and frame_done describing the frame that ended.
  always_comb begin
    frame_done_d = frame_end;
    last_d       = last_q;
    min_d        = min_q;
    max_d        = max_q;
    fcnt_d       = fcnt_q;
    bcnt_d       = bcnt_q;
    ecnt_d       = ecnt_q;
    if (frame_end) begin
      last_d = frame_total;
      fcnt_d = fcnt_inc_w[CNT_WIDTH-1:0];
      bcnt_d = bcnt_sum_w[CNT_WIDTH-1:0];
      if (frame_total < min_q) begin
        min_d = frame_total;
      end
      if (frame_total > max_q) begin
        max_d = frame_total;
      end
    end
    if (accept && beat_malformed) begin
      ecnt_d = ecnt_inc_w[CNT_WIDTH-1:0];
    end
    if (stats_clear) begin
      fcnt_d = '0;
      bcnt_d = '0;
      ecnt_d = '0;
      max_d  = '0;
      min_d  = '1;
    end
  end

  // Registered statistics outputs.
  always_ff @(posedge clk_rx or negedge aresetn) begin
    if (!aresetn) begin
      frame_done_q <= 1'b0;
      last_q       <= '0;
      min_q        <= '1;
      max_q        <= '0;
      fcnt_q       <= '0;
      bcnt_q       <= '0;
      ecnt_q       <= '0;
    end else begin
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      min_q        <= min_d;
      max_q        <= max_d;
      fcnt_q       <= fcnt_d;
      bcnt_q       <= bcnt_d;
      ecnt_q       <= ecnt_d;
    end
  end

  // Upper bits of the wide helper results are never needed.
  logic unused_wide_bits;
  assign unused_wide_bits = ^{pop_wide, acc_sum_w, fcnt_inc_w, bcnt_sum_w, ecnt_inc_w};

  assign frame_done       = frame_done_q;
  assign last_frame_bytes = last_q;
  assign min_frame_bytes  = min_q;
  assign max_frame_bytes  = max_q;
  assign frame_count      = fcnt_q;
  assign byte_count       = bcnt_q;
  assign error_count      = ecnt_q;

endmodule

// File: tb/tb_rx_frame_stats.sv
// Directed bench for rx_frame_stats: stream integrity, timing and statistics.
module tb_rx_frame_stats;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int CW = 32;
  localparam int BW = DW + KW + 1;

  localparam logic [KW-1:0] K_FULL = {KW{1'b1}};
  localparam logic [CW-1:0] C_ONES = {CW{1'b1}};

  logic          clk_rx = 1'b0;
  logic          aresetn;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tready;
  logic          stats_clear;
  logic          frame_done;
  logic [CW-1:0] last_b, min_b, max_b, fcnt, bcnt, ecnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_cnt  = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];

  rx_frame_stats #(
    .AXIS_DATA_WIDTH (DW),
    .AXIS_KEEP_WIDTH (KW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_rx           (clk_rx),
    .aresetn          (aresetn),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (m_tready),
    .stats_clear      (stats_clear),
    .frame_done       (frame_done),
    .last_frame_bytes (last_b),
    .min_frame_bytes  (min_b),
    .max_frame_bytes  (max_b),
    .frame_count      (fcnt),
    .byte_count       (bcnt),
    .error_count      (ecnt)
  );

  always #5 clk_rx = ~clk_rx;

  always @(posedge clk_rx) cyc <= cyc + 1;

  // Inputs change just after posedge, so the negedge sees stable handshakes.
  always @(negedge clk_rx) begin
    if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tkeep, m_tdata});
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(id);
    return {16{w}};
  endfunction

  // Present one beat until accepted (bounded); records it as expected output.
  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    logic ok;
    ok = 1'b0;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk_rx);
      if (s_tready) begin
        ok = 1'b1;
        exp_q.push_back({l, k, d});
      end
      @(posedge clk_rx);
      #1;
    end
    s_tvalid = 1'b0;
    chk("beat_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain_and_check(input string tag);
    int n;
    repeat (3) @(posedge clk_rx);
    #1;
    chk({tag, "_beats"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk_beat({tag, "_beat"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    int c0;
    aresetn = 1'b0; m_tready = 1'b1; stats_clear = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0;

    // ---- reset state
    #12;
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_fcnt", fcnt, 32'd0);
    chk("rst_bcnt", bcnt, 32'd0);
    chk("rst_ecnt", ecnt, 32'd0);
    chk("rst_last", last_b, 32'd0);
    chk("rst_min", min_b, C_ONES);
    chk("rst_max", max_b, 32'd0);
    aresetn = 1'b1;
    @(posedge clk_rx); #1;
    chk("ready_after_rst", 32'(s_tready), 32'd1);

    // ---- T1: 3-beat frame 64+64+8 = 136 bytes, free-flowing
    c0 = cyc;
    send_beat(mk(1), K_FULL, 1'b0);
    chk("t1_lat_valid", 32'(m_tvalid), 32'd1);
    chk_beat("t1_lat_data", {m_tlast, m_tkeep, m_tdata}, {1'b0, K_FULL, mk(1)});
    send_beat(mk(2), K_FULL, 1'b0);
    send_beat(mk(3), 64'h0000_0000_0000_00FF, 1'b1);
    chk("t1_cycles", 32'(cyc - c0), 32'd3);
    chk("t1_frame_done", 32'(frame_done), 32'd1);
    chk("t1_last", last_b, 32'd136);
    chk("t1_min", min_b, 32'd136);
    chk("t1_max", max_b, 32'd136);
    chk("t1_fcnt", fcnt, 32'd1);
    chk("t1_bcnt", bcnt, 32'd136);
    chk("t1_ecnt", ecnt, 32'd0);
    @(posedge clk_rx); #1;
    chk("t1_done_pulse", 32'(frame_done), 32'd0);
    drain_and_check("t1");

    // ---- T2: same frame with downstream stalled for 5 cycles
    m_tready = 1'b0;
    send_beat(mk(11), K_FULL, 1'b0);
    send_beat(mk(12), K_FULL, 1'b0);
    chk("t2_full_ready", 32'(s_tready), 32'd0);
    s_tdata = mk(13); s_tkeep = 64'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_rx); #1;
      chk("t2_stall_ready", 32'(s_tready), 32'd0);
    end
    chk_beat("t2_hold_data", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, 1'b0, K_FULL, mk(11)});
    m_tready = 1'b1;
    send_beat(mk(13), 64'hFF, 1'b1);
    chk("t2_fcnt", fcnt, 32'd2);
    chk("t2_bcnt", bcnt, 32'd272);
    chk("t2_last", last_b, 32'd136);
    drain_and_check("t2");

    // ---- T3: clear, then 4-byte frame and 128-byte frame
    stats_clear = 1'b1;
    @(posedge clk_rx); #1;
    stats_clear = 1'b0;
    chk("clr_fcnt", fcnt, 32'd0);
    chk("clr_bcnt", bcnt, 32'd0);
    chk("clr_min", min_b, C_ONES);
    chk("clr_max", max_b, 32'd0);
    chk("clr_keeps_last", last_b, 32'd136);
    send_beat(mk(21), 64'h0F, 1'b1);
    chk("t3_single_done", 32'(frame_done), 32'd1);
    chk("t3_single_last", last_b, 32'd4);
    send_beat(mk(22), K_FULL, 1'b0);
    send_beat(mk(23), K_FULL, 1'b1);
    chk("t3_last", last_b, 32'd128);
    chk("t3_min", min_b, 32'd4);
    chk("t3_max", max_b, 32'd128);
    chk("t3_fcnt", fcnt, 32'd2);
    chk("t3_bcnt", bcnt, 32'd132);
    chk("t3_ecnt", ecnt, 32'd0);
    drain_and_check("t3");

    // ---- T4: malformed keeps (63-byte middle, non-contiguous 0x05 last)
    send_beat(mk(31), 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk("t4_ecnt_mid", ecnt, 32'd1);
    send_beat(mk(32), 64'h05, 1'b1);
    chk("t4_ecnt", ecnt, 32'd2);
    chk("t4_last", last_b, 32'd65);
    chk("t4_fcnt", fcnt, 32'd3);
    chk("t4_bcnt", bcnt, 32'd197);
    drain_and_check("t4");

    // ---- T5: clear coincident with the end of a 64-byte frame
    s_tdata = mk(41); s_tkeep = K_FULL; s_tlast = 1'b1; s_tvalid = 1'b1; stats_clear = 1'b1;
    @(negedge clk_rx);
    chk("t5_accept", 32'(s_tready), 32'd1);
    exp_q.push_back({1'b1, K_FULL, mk(41)});
    @(posedge clk_rx); #1;
    s_tvalid = 1'b0; stats_clear = 1'b0;
    chk("t5_fcnt", fcnt, 32'd0);
    chk("t5_bcnt", bcnt, 32'd0);
    chk("t5_ecnt", ecnt, 32'd0);
    chk("t5_min", min_b, C_ONES);
    chk("t5_max", max_b, 32'd0);
    chk("t5_last", last_b, 32'd64);
    chk("t5_done", 32'(frame_done), 32'd1);
    drain_and_check("t5");

    // ---- T6: reset mid-frame with two beats buffered, then a fresh frame
    m_tready = 1'b0;
    send_beat(mk(51), K_FULL, 1'b0);
    send_beat(mk(52), K_FULL, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_s_tready", 32'(s_tready), 32'd0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    m_tready = 1'b1;
    #3;
    aresetn = 1'b1;
    @(posedge clk_rx); #1;
    chk("t6_no_stale", 32'(m_tvalid), 32'd0);
    send_beat(mk(53), K_FULL, 1'b1);
    chk("t6_fcnt", fcnt, 32'd1);
    chk("t6_bcnt", bcnt, 32'd64);
    chk("t6_last", last_b, 32'd64);
    chk("t6_min", min_b, 32'd64);
    drain_and_check("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
